ram_mp_param: RTL

- Parametrised successor to the team's 8x16 dual-read/single-write RAM.
- Generalised in data width, depth and read-port count; reads are registered with a valid flag.
- Configurable read-during-write bypass.
- Sequential clear engine zeroes the array after reset or on request, with a busy flag.
- Sits between the datapath/register-file layer and the controller, which may issue one write and N_RD reads per cycle.

---
 rtl/ram_mp_param.sv | 90 +++++++++
 1 files changed

// File: rtl/ram_mp_param.sv
// Parametrised multi-read-port, single-write-port RAM with registered reads,
// optional read-during-write bypass and a sequential clear engine.
module ram_mp_param #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 3,
    parameter int N_RD       = 2,
    parameter int BYPASS     = 1,
    parameter int CLR_ON_RST = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic                     clr,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [N_RD-1:0]          rd_en,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    output logic [N_RD-1:0]          rd_valid,
    output logic                     busy
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_acc;

    assign busy   = (state == CLEAR);
    assign wr_acc = ce & we & ~busy;

    // Clear engine: clr restarts the sweep from entry 0 even mid-sequence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
            ptr   <= '0;
        end else if (clr) begin
            state <= CLEAR;
            ptr   <= '0;
        end else if (state == CLEAR) begin
            ptr <= ptr + 1'b1;
            if (ptr == {ADDR_W{1'b1}}) begin
                state <= IDLE;
            end
        end
    end

    // The array itself is never touched on a reset edge.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR) begin
                mem[ptr] <= '0;
            end else if (wr_acc) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    for (genvar i = 0; i < N_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra_p0;
        logic              hit_p0;
        logic [DATA_W-1:0] data_p1;
        logic              vld_p1;

        assign ra_p0  = rd_addr[i*ADDR_W +: ADDR_W];
        assign hit_p0 = (BYPASS != 0) && wr_acc && (wr_addr == ra_p0);

        // Stage p0 -> p1: registered read; data holds when the port is idle.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                data_p1 <= '0;
                vld_p1  <= 1'b0;
            end else if (ce & rd_en[i] & ~busy) begin
                data_p1 <= hit_p0 ? wr_data : mem[ra_p0];
                vld_p1  <= 1'b1;
            end else begin
                vld_p1  <= 1'b0;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = data_p1;
        assign rd_valid[i]                 = vld_p1;
    end

endmodule
